// File: rtl/calc_controller_if.sv
// Keypad-event and display bundle shared by the scanner, the controller and the display driver.
interface calc_controller_if #(parameter int W = 14);
  logic         key_released;
  logic [3:0]   key_digit;
  logic [3:0]   key_oper;
  logic [W-1:0] value;
  logic         err;
  logic         busy;
  logic [2:0]   op_pending;

  modport master (
    output key_released, key_digit, key_oper,
    input  value, err, busy, op_pending
  );
  modport slave (
    input  key_released, key_digit, key_oper,
    output value, err, busy, op_pending
  );
endinterface

// File: rtl/calc_controller.sv
// Calculator sequencer: decimal operand entry, left-to-right operator chaining and a
// multi-cycle add/sub/mul/div datapath driving the seven-segment display value.
module calc_controller #(
  parameter int W   = 14,
  parameter int MAX = 9999
) (
  input logic              clk,
  input logic              rst,
  calc_controller_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [W+3:0]   MAX_E = (W+4)'(MAX);
  localparam logic [2*W-1:0] MAX_P = (2*W)'(MAX);
  localparam logic [2:0] OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_DIV = 3'd4;

  typedef enum logic [2:0] {S_ENTRY_A, S_OP_WAIT, S_ENTRY_B, S_EXEC, S_RESULT, S_ERROR} state_t;

  state_t         r_state;
  logic [W-1:0]   r_a, r_b, r_value, r_quo, r_rem;
  logic [2:0]     r_op, r_next_op, r_op_pending;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic           r_err, r_busy;

  logic           w_digit, w_arith, w_equals, w_clear;
  logic [2:0]     w_code;
  logic [W-1:0]   w_d;
  logic [W+3:0]   w_a_ent, w_b_ent;
  logic [2*W-1:0] w_sum, w_acc_next;
  logic [CW-1:0]  w_idx;
  logic [W:0]     w_rem_sh;
  logic           w_rem_ge;
  logic [W-1:0]   w_rem_next, w_quo_next;
  logic           w_done, w_res_err;
  logic [W-1:0]   w_res;

  assign w_digit  = bus.key_released && (bus.key_oper == 4'd0);
  assign w_arith  = bus.key_released && (bus.key_oper >= 4'd1) && (bus.key_oper <= 4'd4);
  assign w_equals = bus.key_released && (bus.key_oper == 4'd6);
  assign w_clear  = bus.key_released && (bus.key_oper == 4'd5);
  assign w_code   = bus.key_oper[2:0];
  assign w_d      = {{(W-4){1'b0}}, bus.key_digit};

  assign w_a_ent = {4'd0, r_a} * (W+4)'(10) + (W+4)'(bus.key_digit);
  assign w_b_ent = {4'd0, r_b} * (W+4)'(10) + (W+4)'(bus.key_digit);
  assign w_sum   = (2*W)'(r_a) + (2*W)'(r_b);

  // Both mul and div walk the operand bits MSB first, one bit per EXEC cycle.
  assign w_idx      = CW'(W-1) - r_cnt;
  assign w_acc_next = (r_acc << 1) + (r_b[w_idx] ? (2*W)'(r_a) : '0);
  assign w_rem_sh   = {r_rem, r_a[w_idx]};
  assign w_rem_ge   = w_rem_sh >= {1'b0, r_b};
  assign w_rem_next = w_rem_ge ? W'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[W-1:0];
  assign w_quo_next = r_quo | (W'(w_rem_ge) << w_idx);

  always_comb begin
    w_done    = 1'b1;
    w_res     = '0;
    w_res_err = 1'b1;
    case (r_op)
      OP_ADD: begin w_res = w_sum[W-1:0]; w_res_err = w_sum > MAX_P; end
      OP_SUB: begin w_res = r_a - r_b;    w_res_err = r_a < r_b;     end
      OP_MUL: begin
        w_done    = (r_cnt == CW'(W-1));
        w_res     = w_acc_next[W-1:0];
        w_res_err = w_acc_next > MAX_P;
      end
      OP_DIV: begin
        w_done    = (r_cnt == CW'(W-1));
        w_res     = w_quo_next;
        w_res_err = (r_b == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clear) begin
      r_state <= S_ENTRY_A;
      r_a <= '0; r_b <= '0; r_op <= '0; r_next_op <= '0;
      r_cnt <= '0; r_acc <= '0; r_rem <= '0; r_quo <= '0;
      r_value <= '0; r_err <= 1'b0; r_busy <= 1'b0; r_op_pending <= '0;
    end else begin
      case (r_state)
        S_ENTRY_A: begin
          if (w_digit && (w_a_ent <= MAX_E)) begin
            r_a     <= w_a_ent[W-1:0];
            r_value <= w_a_ent[W-1:0];
          end else if (w_arith) begin
            r_op <= w_code; r_op_pending <= w_code; r_state <= S_OP_WAIT;
          end
        end
        S_OP_WAIT: begin
          if (w_digit) begin
            r_b <= w_d; r_value <= w_d; r_state <= S_ENTRY_B;
          end else if (w_arith) begin
            r_op <= w_code; r_op_pending <= w_code;
          end
        end
        S_ENTRY_B: begin
          if (w_digit && (w_b_ent <= MAX_E)) begin
            r_b     <= w_b_ent[W-1:0];
            r_value <= w_b_ent[W-1:0];
          end else if (w_equals || w_arith) begin
            r_next_op <= w_equals ? 3'd0 : w_code;
            r_state   <= S_EXEC;
            r_busy    <= 1'b1;
            r_cnt <= '0; r_acc <= '0; r_rem <= '0; r_quo <= '0;
          end
        end
        S_EXEC: begin
          if (!w_done) begin
            r_cnt <= r_cnt + 1'b1; r_acc <= w_acc_next; r_rem <= w_rem_next; r_quo <= w_quo_next;
          end else begin
            r_busy <= 1'b0;
            if (w_res_err) begin
              r_state <= S_ERROR; r_err <= 1'b1; r_value <= '0; r_op_pending <= '0;
              r_a <= '0; r_b <= '0; r_op <= '0; r_next_op <= '0;
            end else begin
              r_a <= w_res; r_b <= '0; r_value <= w_res;
              r_op <= r_next_op; r_op_pending <= r_next_op;
              r_state <= (r_next_op != 3'd0) ? S_OP_WAIT : S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (w_digit) begin
            r_a <= w_d; r_value <= w_d; r_state <= S_ENTRY_A;
          end else if (w_arith) begin
            r_op <= w_code; r_op_pending <= w_code; r_state <= S_OP_WAIT;
          end
        end
        S_ERROR: ;
        default: r_state <= S_ENTRY_A;
      endcase
    end
  end

  assign bus.value      = r_value;
  assign bus.err        = r_err;
  assign bus.busy       = r_busy;
  assign bus.op_pending = r_op_pending;
endmodule
